dsp48a1_mac_seq: RTL
====================

# dsp48a1_mac_seq

Sequencer that runs signed multiply-accumulate (dot-product) jobs on a DSP48A1 slice instantiated with A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT" and the pre-adder bypassed. It accepts a job length and a valid/ready stream of 18-bit operand pairs. It drives the slice's data, clock-enable, P-reset and OPMODE pins so that P accumulates exactly the accepted products, tolerating input bubbles. It then returns the 48-bit sum. It sits between a stream source and one DSP48A1 slice.

## Interface
- LEN_W, 8: width of job length; max job = 2^LEN_W-1 products (44-bit worst-case sum, no overflow in 48 bits at default)
- clk  in  1  rising-edge clock, also drives the slice
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled in IDLE only
- len  in  LEN_W  number of operand pairs, sampled with start
- abort  in  1  synchronous job cancel, honoured in CLR/RUN/DRAIN
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept a pair
- a_in, b_in  in  18 each  signed operands
- dsp_a, dsp_b  out  18 each  to slice A, B (combinational pass of a_in, b_in)
- dsp_cea, dsp_ceb  out  1  A1/B1 register enables
- dsp_cem  out  1  M register enable
- dsp_cep  out  1  P register enable
- dsp_rstp  out  1  P register synchronous reset (active high)
- dsp_opmode  out  8  constant 8'h09 (X=M, Z=P, add, no carry, pre-adder off)
- dsp_ceopmode  out  1  high in IDLE, low otherwise
- dsp_p  in  48  slice P output
- res_valid  out  1  one-cycle result strobe
- res_data  out  48  signed result, held until next accepted start

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE:
  - start && len!=0 -> CLR; latch len into remaining counter.
  - start && len==0 -> DONE with zero-result flag set; no DSP activity.
- CLR: dsp_rstp=1 for one cycle; clear the valid pipe -> RUN.
- RUN:
  - in_ready=1.
  - accept = in_valid && in_ready; dsp_cea = dsp_ceb = accept.
  - Each accept decrements remaining; the accept that brings remaining to 0 -> DRAIN, and in_ready drops in the next cycle.
- Valid pipe (2 flops):
  - v1 <= accept; v2 <= v1.
  - dsp_cem = v1; dsp_cep = v2.
  - Bubbles freeze M/P, so P = sum of accepted a*b only.
- DRAIN: exactly PIPE-1 = 2 cycles (the last product reaches P) -> DONE.
- DONE:
  - Register res_data <= (zero flag ? 0 : dsp_p).
  - res_valid=1 in the next cycle.
  - -> IDLE.
- abort in CLR/RUN/DRAIN:
  - -> IDLE next cycle; dsp_rstp=1 that cycle.
  - Valid pipe cleared; no res_valid; res_data unchanged.
- start while busy is ignored. abort in IDLE/DONE is ignored.
- Arithmetic: the slice computes the full signed 18x18 -> 36-bit product, sign-extended into the 48-bit post-adder; the controller does no arithmetic on data.
- Reset values:
  - state IDLE.
  - in_ready, busy, res_valid, dsp_cea/ceb/cem/cep, dsp_rstp all 0.
  - res_data 0; dsp_ceopmode 1; dsp_opmode 8'h09.
  - Valid pipe, counter and zero flag 0.
  - rst_n mid-job drops the job immediately with no res_valid. The next job's CLR clears stale slice contents.

## Timing
- Start accepted in cycle t: CLR in t+1, RUN from t+2; the first possible accept is t+2.
- Operand accepted in cycle k: A1/B1 capture at end of k; cem=1 in k+1; cep=1 in k+2; P includes it in k+3.
- Last accept in cycle L: DRAIN L+1..L+2; DONE L+3 (samples dsp_p); res_valid high in L+4 only.
- len==0: start in t, DONE t+1, res_valid t+2.
- Back-to-back jobs: a new start is honoured in the cycle res_valid is high (IDLE).
- The outputs in_ready, busy, res_valid and res_data are registered. dsp_cea, dsp_ceb and dsp_a/b are combinational from in_valid/a_in/b_in.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs at reset values, dsp_opmode=8'h09; release -> stays IDLE until start.
- len=4, a={1,2,3,4}, b={5,6,7,8} back-to-back -> exactly 4 accepts, res_data=70, res_valid 4 cycles after the last accept, busy low after.
- len=2, a={-3,131071}, b={7,131071} -> res_data=17179607020; len=1, a=-131072, b=131071 -> res_data=-17179738112 (sign-extended to 48 bits).
- len=3, a=b-pairs {2,3} three times, in_valid toggling 1,0,0,1,0,1 -> res_data=18; cep high exactly 3 cycles, each 2 cycles after its accept.
- len=0 -> res_valid 2 cycles after start, res_data=0, no cea/cep/rstp activity.
- abort in RUN after 2 of 5 accepts, then rst_n pulse during a second job, then clean job len=2 a={10,10} b={10,10} -> no res_valid for the aborted or reset jobs, final res_data=200.

Source files
------------

// File: rtl/dsp48a1_mac_seq.sv
// Dot-product sequencer for one DSP48A1 slice (A1/B1, M, P and OPMODE registered).
// Drives the slice clock enables so P accumulates only accepted operand pairs.
module dsp48a1_mac_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      a_in,
  input  logic [17:0]      b_in,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ceopmode,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  output logic [47:0]      res_data,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             drain_cnt;
  logic             zero_flag;
  logic             v1;
  logic             v2;
  logic             accept;
  logic             abort_now;
  logic             pipe_clear;

  // Handshake: a pair transfers in any cycle where in_valid && in_ready;
  // in_ready is registered and never depends on in_valid.
  assign accept     = in_valid && in_ready;
  assign abort_now  = abort && (state == S_CLR || state == S_RUN || state == S_DRAIN);
  assign pipe_clear = (state == S_CLR) || abort_now;

  assign dsp_a        = a_in;
  assign dsp_b        = b_in;
  assign dsp_cea      = accept;
  assign dsp_ceb      = accept;
  assign dsp_cem      = v1;
  assign dsp_cep      = v2;
  assign dsp_rstp     = pipe_clear;
  assign dsp_opmode   = 8'h09;
  assign dsp_ceopmode = (state == S_IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      drain_cnt <= 1'b0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state     <= S_CLR;
              remaining <= len;
              zero_flag <= 1'b0;
            end else begin
              state     <= S_DONE;
              zero_flag <= 1'b1;
            end
          end
        end
        S_CLR: begin
          state    <= S_RUN;
          in_ready <= 1'b1;
        end
        S_RUN: begin
          if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state     <= S_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Two cycles let the last product move M -> P.
          if (drain_cnt) state <= S_DONE;
          else           drain_cnt <= 1'b1;
        end
        S_DONE: begin
          res_data  <= zero_flag ? 48'd0 : dsp_p;
          res_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
      if (abort_now) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        in_ready <= 1'b0;
      end
    end
  end

  // Valid pipe mirrors the slice M and P stages so bubbles freeze both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept && !pipe_clear;
      v2 <= v1 && !pipe_clear;
    end
  end

endmodule
